// File: rtl/core_161c.sv
// core_161c: 16K x 36-bit PDP-10 core memory bank serving four membus ports (p0 highest priority).
// Define MEM_WR_TIMEOUT_EN to abort write waits (HOLD/WWAIT) that last longer than 1024 cycles.
module core_161c #(
    parameter logic [3:0] memsel_p0 = 4'b0,
    parameter logic [3:0] memsel_p1 = 4'b0,
    parameter logic [3:0] memsel_p2 = 4'b0,
    parameter logic [3:0] memsel_p3 = 4'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power,
    input  logic        sw_single_step,
    input  logic        sw_restart,
    input  logic        membus_rq_cyc_p0,
    input  logic        membus_rd_rq_p0,
    input  logic        membus_wr_rq_p0,
    input  logic [14:0] membus_ma_p0,
    input  logic [3:0]  membus_sel_p0,
    input  logic        membus_fmc_select_p0,
    input  logic        membus_wr_rs_p0,
    input  logic [35:0] membus_mb_in_p0,
    output logic        membus_addr_ack_p0,
    output logic        membus_rd_rs_p0,
    output logic [35:0] membus_mb_out_p0,
    input  logic        membus_rq_cyc_p1,
    input  logic        membus_rd_rq_p1,
    input  logic        membus_wr_rq_p1,
    input  logic [14:0] membus_ma_p1,
    input  logic [3:0]  membus_sel_p1,
    input  logic        membus_fmc_select_p1,
    input  logic        membus_wr_rs_p1,
    input  logic [35:0] membus_mb_in_p1,
    output logic        membus_addr_ack_p1,
    output logic        membus_rd_rs_p1,
    output logic [35:0] membus_mb_out_p1,
    input  logic        membus_rq_cyc_p2,
    input  logic        membus_rd_rq_p2,
    input  logic        membus_wr_rq_p2,
    input  logic [14:0] membus_ma_p2,
    input  logic [3:0]  membus_sel_p2,
    input  logic        membus_fmc_select_p2,
    input  logic        membus_wr_rs_p2,
    input  logic [35:0] membus_mb_in_p2,
    output logic        membus_addr_ack_p2,
    output logic        membus_rd_rs_p2,
    output logic [35:0] membus_mb_out_p2,
    input  logic        membus_rq_cyc_p3,
    input  logic        membus_rd_rq_p3,
    input  logic        membus_wr_rq_p3,
    input  logic [14:0] membus_ma_p3,
    input  logic [3:0]  membus_sel_p3,
    input  logic        membus_fmc_select_p3,
    input  logic        membus_wr_rs_p3,
    input  logic [35:0] membus_mb_in_p3,
    output logic        membus_addr_ack_p3,
    output logic        membus_rd_rs_p3,
    output logic [35:0] membus_mb_out_p3
);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_READ, S_HOLD, S_WWAIT, S_DONE} state_t;

    // Bus bit 0 (PDP-10 MSB) maps to [35]; ma bit 21 is [14] and does not index the core.
    logic [35:0] core [0:16383];

    logic [3:0]  rq_cyc, rd_rq, wr_rq, wr_rs, qual, ack, rd_rs;
    logic [13:0] ma [4];
    logic [35:0] mb_in [4];
    logic        unused_ma_bit21;

    assign rq_cyc = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
    assign rd_rq  = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
    assign wr_rq  = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
    assign wr_rs  = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};
    assign ma     = '{membus_ma_p0[13:0], membus_ma_p1[13:0], membus_ma_p2[13:0], membus_ma_p3[13:0]};
    assign mb_in  = '{membus_mb_in_p0, membus_mb_in_p1, membus_mb_in_p2, membus_mb_in_p3};
    assign unused_ma_bit21 = ^{membus_ma_p0[14], membus_ma_p1[14], membus_ma_p2[14], membus_ma_p3[14]};

    assign qual[0] = power & membus_rq_cyc_p0 & (membus_sel_p0 == memsel_p0) & ~membus_fmc_select_p0;
    assign qual[1] = power & membus_rq_cyc_p1 & (membus_sel_p1 == memsel_p1) & ~membus_fmc_select_p1;
    assign qual[2] = power & membus_rq_cyc_p2 & (membus_sel_p2 == memsel_p2) & ~membus_fmc_select_p2;
    assign qual[3] = power & membus_rq_cyc_p3 & (membus_sel_p3 == memsel_p3) & ~membus_fmc_select_p3;

    state_t      state_q, state_d, write_entry;
    logic [1:0]  port_q, port_d, win;
    logic [13:0] addr_q, addr_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        mem_we, rd_load, tmo_hit;
    logic [35:0] rd_data_q;

`ifdef MEM_WR_TIMEOUT_EN
    logic [10:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = (state_q == S_HOLD || state_q == S_WWAIT) ? tmo_q + 11'd1 : 11'd0;
        tmo_hit = (tmo_q == 11'd1024);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        win = 2'd0;
        if (qual[0])      win = 2'd0;
        else if (qual[1]) win = 2'd1;
        else if (qual[2]) win = 2'd2;
        else if (qual[3]) win = 2'd3;
    end

    assign write_entry = sw_single_step ? S_HOLD : S_WWAIT;

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_we  = 1'b0;
        rd_load = 1'b0;
        case (state_q)
            S_IDLE: if (qual != 4'b0) begin
                state_d = S_ACK;
                port_d  = win;
                addr_d  = ma[win];
                rd_d    = rd_rq[win];
                wr_d    = wr_rq[win];
            end
            S_ACK: begin
                if (rd_q) begin
                    state_d = S_READ;
                    rd_load = 1'b1;
                end else if (wr_q) begin
                    state_d = write_entry;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_READ:  state_d = wr_q ? write_entry : S_DONE;
            S_HOLD: begin
                if (tmo_hit)         state_d = S_DONE;
                else if (sw_restart) state_d = S_WWAIT;
            end
            S_WWAIT: begin
                if (wr_rs[port_q]) begin
                    mem_we  = !reset;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (!rq_cyc[port_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Losing power aborts the cycle exactly like reset.
        if (!power) begin
            state_d = S_IDLE;
            mem_we  = 1'b0;
            rd_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            port_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // NOTE: the core array and its read register carry no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we)  core[addr_q] <= mb_in[port_q];
        if (rd_load) rd_data_q    <= core[addr_q];
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ack[n]   = power && !reset && (state_q == S_ACK)  && (port_q == 2'(n));
            rd_rs[n] = power && !reset && (state_q == S_READ) && (port_q == 2'(n));
        end
    end

    assign membus_addr_ack_p0 = ack[0];
    assign membus_addr_ack_p1 = ack[1];
    assign membus_addr_ack_p2 = ack[2];
    assign membus_addr_ack_p3 = ack[3];
    assign membus_rd_rs_p0    = rd_rs[0];
    assign membus_rd_rs_p1    = rd_rs[1];
    assign membus_rd_rs_p2    = rd_rs[2];
    assign membus_rd_rs_p3    = rd_rs[3];
    assign membus_mb_out_p0   = rd_rs[0] ? rd_data_q : 36'd0;
    assign membus_mb_out_p1   = rd_rs[1] ? rd_data_q : 36'd0;
    assign membus_mb_out_p2   = rd_rs[2] ? rd_data_q : 36'd0;
    assign membus_mb_out_p3   = rd_rs[3] ? rd_data_q : 36'd0;

endmodule

// File: tb/tb_core_161c.sv
// tb_core_161c: randomized read/write/RMW traffic on all four ports against an array model of the core.
module tb_core_161c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, power, sw_single_step, sw_restart;
    logic [3:0]  rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
    logic [14:0] ma [4];
    logic [3:0]  sel [4];
    logic [35:0] mb_in [4];
    wire  [3:0]  ack_o, rd_rs_o;
    wire  [35:0] mb_out_o [4];

    localparam logic [3:0] STRAP2 = 4'd5;

    logic [35:0] model [16384];
    int errors = 0;
    int checks = 0;

    core_161c #(.memsel_p2(STRAP2)) dut (
        .clk(clk), .reset(reset), .power(power),
        .sw_single_step(sw_single_step), .sw_restart(sw_restart),
        .membus_rq_cyc_p0(rq_cyc[0]), .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]),
        .membus_ma_p0(ma[0]), .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]),
        .membus_wr_rs_p0(wr_rs[0]), .membus_mb_in_p0(mb_in[0]),
        .membus_addr_ack_p0(ack_o[0]), .membus_rd_rs_p0(rd_rs_o[0]), .membus_mb_out_p0(mb_out_o[0]),
        .membus_rq_cyc_p1(rq_cyc[1]), .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]),
        .membus_ma_p1(ma[1]), .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]),
        .membus_wr_rs_p1(wr_rs[1]), .membus_mb_in_p1(mb_in[1]),
        .membus_addr_ack_p1(ack_o[1]), .membus_rd_rs_p1(rd_rs_o[1]), .membus_mb_out_p1(mb_out_o[1]),
        .membus_rq_cyc_p2(rq_cyc[2]), .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]),
        .membus_ma_p2(ma[2]), .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]),
        .membus_wr_rs_p2(wr_rs[2]), .membus_mb_in_p2(mb_in[2]),
        .membus_addr_ack_p2(ack_o[2]), .membus_rd_rs_p2(rd_rs_o[2]), .membus_mb_out_p2(mb_out_o[2]),
        .membus_rq_cyc_p3(rq_cyc[3]), .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]),
        .membus_ma_p3(ma[3]), .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]),
        .membus_wr_rs_p3(wr_rs[3]), .membus_mb_in_p3(mb_in[3]),
        .membus_addr_ack_p3(ack_o[3]), .membus_rd_rs_p3(rd_rs_o[3]), .membus_mb_out_p3(mb_out_o[3])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_ack, input logic [3:0] e_rd,
                              input logic [35:0] e_data);
        check({tag, ".ack"}, 64'(ack_o), 64'(e_ack));
        check({tag, ".rd_rs"}, 64'(rd_rs_o), 64'(e_rd));
        for (int n = 0; n < 4; n++)
            check($sformatf("%s.mb_out%0d", tag, n), 64'(mb_out_o[n]), e_rd[n] ? 64'(e_data) : 64'd0);
    endtask

    function automatic logic [3:0] strap(input int p);
        return (p == 2) ? STRAP2 : 4'd0;
    endfunction

    function automatic logic [35:0] rand36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int p, input bit rd, input bit wr, input logic [13:0] a);
        rq_cyc[p] = 1'b1;
        rd_rq[p]  = rd;
        wr_rq[p]  = wr;
        ma[p]     = {1'($urandom), a};
        sel[p]    = strap(p);
        fmc[p]    = 1'b0;
    endtask

    task automatic drop_req(input int p);
        rq_cyc[p] = 1'b0;
        rd_rq[p]  = 1'b0;
        wr_rq[p]  = 1'b0;
    endtask

    // One full bus cycle; expectations come from the model array and the fixed bus latencies.
    task automatic txn(input int p, input bit rd, input bit wr, input logic [13:0] a,
                       input logic [35:0] wd, input int gap);
        logic [3:0] pm;
        int q;
        pm = 4'b1 << p;
        q  = (p + 1) % 4;
        tick();
        drive_req(p, rd, wr, a);
        @(negedge clk); check_outs("req_cycle", 4'b0, 4'b0, 36'd0);
        @(negedge clk); check_outs("ack", pm, 4'b0, 36'd0);
        if (rd) begin
            @(negedge clk); check_outs("rd_rs", 4'b0, pm, model[a]);
            @(negedge clk); check_outs("rd_clear", 4'b0, 4'b0, 36'd0);
        end else begin
            @(negedge clk); check_outs("no_rd", 4'b0, 4'b0, 36'd0);
        end
        if (wr) begin
            if (gap > 0) begin
                tick();
                wr_rs[q] = 1'b1;
                mb_in[q] = rand36();
                tick();
                wr_rs[q] = 1'b0;
                check("foreign_wr_rs", 64'(dut.core[a]), 64'(model[a]));
                repeat (gap - 1) tick();
            end
            tick();
            for (int n = 0; n < 4; n++) mb_in[n] = rand36();
            mb_in[p] = wd;
            wr_rs[p] = 1'b1;
            tick();
            wr_rs[p] = 1'b0;
            model[a] = wd;
            check("write", 64'(dut.core[a]), 64'(model[a]));
        end else begin
            tick();
        end
        drop_req(p);
    endtask

    task automatic reject(input int p, input bit use_fmc, input logic [13:0] a);
        tick();
        drive_req(p, 1'b1, 1'b1, a);
        if (use_fmc) fmc[p] = 1'b1;
        else         sel[p] = strap(p) ^ 4'd1;
        repeat (3) @(negedge clk);
        check_outs("reject", 4'b0, 4'b0, 36'd0);
        tick();
        wr_rs[p] = 1'b1;
        mb_in[p] = rand36();
        tick();
        wr_rs[p] = 1'b0;
        check("reject_core", 64'(dut.core[a]), 64'(model[a]));
        drop_req(p);
        fmc[p] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
        rq_cyc = '0; rd_rq = '0; wr_rq = '0; fmc = '0; wr_rs = '0;
        for (int n = 0; n < 4; n++) begin
            ma[n] = '0; sel[n] = '0; mb_in[n] = '0;
        end
        for (int i = 0; i < 16384; i++) begin
            model[i]    = rand36();
            dut.core[i] = model[i];
        end
        model['o26]    = 36'o145000_123456;
        dut.core['o26] = model['o26];
        model['o42]    = 36'o265740_000000;
        dut.core['o42] = model['o42];

        repeat (3) tick();
        @(negedge clk); check_outs("reset", 4'b0, 4'b0, 36'd0);
        tick();
        reset = 1'b0;

        txn(0, 1'b1, 1'b0, 14'o26, 36'd0, 0);
        txn(0, 1'b0, 1'b1, 14'o100, 36'o777777_000001, 0);
        txn(0, 1'b1, 1'b1, 14'o42, 36'd5, 1);
        txn(3, 1'b1, 1'b0, 14'h3fff, 36'd0, 0);
        txn(2, 1'b1, 1'b1, 14'h0000, 36'hf_ffff_ffff, 2);

        reject(0, 1'b1, 14'o26);
        reject(0, 1'b0, 14'o26);
        reject(2, 1'b0, 14'o42);

        // p0 and p1 together: p0 served first, p1 only after p0 releases rq_cyc.
        tick();
        drive_req(0, 1'b1, 1'b0, 14'd7);
        drive_req(1, 1'b1, 1'b0, 14'd9);
        @(negedge clk);
        @(negedge clk); check_outs("arb_ack0", 4'b0001, 4'b0, 36'd0);
        @(negedge clk); check_outs("arb_rd0", 4'b0, 4'b0001, model[7]);
        @(negedge clk); check_outs("arb_wait", 4'b0, 4'b0, 36'd0);
        tick();
        drop_req(0);
        @(negedge clk); check_outs("arb_release", 4'b0, 4'b0, 36'd0);
        @(negedge clk); check_outs("arb_idle", 4'b0, 4'b0, 36'd0);
        @(negedge clk); check_outs("arb_ack1", 4'b0010, 4'b0, 36'd0);
        @(negedge clk); check_outs("arb_rd1", 4'b0, 4'b0010, model[9]);
        tick();
        drop_req(1);

        // Reset during the ack cycle of a read.
        tick();
        drive_req(0, 1'b1, 1'b0, 14'o26);
        tick();
        reset = 1'b1;
        @(negedge clk); check_outs("rst_ack", 4'b0, 4'b0, 36'd0);
        tick();
        reset = 1'b0;
        drop_req(0);
        @(negedge clk); check_outs("rst_after", 4'b0, 4'b0, 36'd0);
        @(negedge clk); check_outs("rst_after2", 4'b0, 4'b0, 36'd0);

        // Power loss during the ack cycle of a read.
        tick();
        drive_req(1, 1'b1, 1'b0, 14'o42);
        tick();
        power = 1'b0;
        @(negedge clk); check_outs("pwr_ack", 4'b0, 4'b0, 36'd0);
        tick();
        power = 1'b1;
        drop_req(1);
        @(negedge clk); check_outs("pwr_after", 4'b0, 4'b0, 36'd0);

        // Reset coinciding with wr_rs in the write wait: no write may land.
        tick();
        drive_req(0, 1'b0, 1'b1, 14'd33);
        @(negedge clk);
        @(negedge clk); check_outs("rstw_ack", 4'b0001, 4'b0, 36'd0);
        tick();
        reset = 1'b1;
        wr_rs[0] = 1'b1;
        mb_in[0] = ~model[33];
        tick();
        reset = 1'b0;
        wr_rs[0] = 1'b0;
        drop_req(0);
        check("rstw_core", 64'(dut.core[33]), 64'(model[33]));

        // Single step: wr_rs during HOLD is ignored until sw_restart.
        sw_single_step = 1'b1;
        tick();
        drive_req(0, 1'b0, 1'b1, 14'd50);
        @(negedge clk);
        @(negedge clk); check_outs("ss_ack", 4'b0001, 4'b0, 36'd0);
        tick();
        wr_rs[0] = 1'b1;
        mb_in[0] = 36'o123456_654321;
        tick();
        wr_rs[0] = 1'b0;
        check("ss_hold", 64'(dut.core[50]), 64'(model[50]));
        sw_restart = 1'b1;
        tick();
        sw_restart = 1'b0;
        wr_rs[0] = 1'b1;
        tick();
        wr_rs[0] = 1'b0;
        model[50] = 36'o123456_654321;
        check("ss_write", 64'(dut.core[50]), 64'(model[50]));
        drop_req(0);
        sw_single_step = 1'b0;

        for (int k = 0; k < 40; k++) begin
            int p, kind;
            logic [13:0] a;
            p    = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            a    = ($urandom_range(0, 7) == 0) ? 14'h3fff : 14'($urandom_range(0, 31));
            txn(p, kind != 1, kind != 0, a, rand36(), $urandom_range(0, 3));
        end
        for (int k = 0; k < 4; k++)
            reject($urandom_range(0, 3), 1'($urandom), 14'($urandom_range(0, 31)));

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
